exu_wb_arb: RTL and testbench

//   Writeback arbiter directly downstream of the 3-stage multiplier. Merges the

---
 rtl/exu_wb_arb.sv | 136 +++++++++++++
 tb/tb_exu_wb_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: merges multiplier, ALU (with holding FIFO) and LSU results
// onto the single register-file write port with a registered output stage.
module exu_wb_arb #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ALU_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] mul_data,
   input  logic [4:0]      mul_rd_addr,
   input  logic            mul_rd_wr_en,
   input  logic [XLEN-1:0] mul_instr_tag,
   input  logic [31:0]     mul_instr,
   input  logic            alu_valid,
   input  logic [XLEN-1:0] alu_data,
   input  logic [4:0]      alu_rd_addr,
   input  logic [XLEN-1:0] alu_instr_tag,
   input  logic [31:0]     alu_instr,
   output logic            alu_full,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [XLEN-1:0] lsu_data,
   input  logic [4:0]      lsu_rd_addr,
   input  logic [XLEN-1:0] lsu_instr_tag,
   input  logic [31:0]     lsu_instr,
   output logic            wb_wr_en,
   output logic [4:0]      wb_rd_addr,
   output logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] wb_instr_tag,
   output logic [31:0]     wb_instr,
   output logic [31:0]     wb_retire_cnt
);

   localparam int unsigned PW = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [4:0]      rd;
      logic [XLEN-1:0] tag;
      logic [31:0]     instr;
   } wb_rec_t;

   wb_rec_t        fifo_q [ALU_DEPTH];
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           full_q, full_d;

   wb_rec_t        mul_rec, alu_rec, lsu_rec, sel_rec;
   logic           fifo_empty, sel_mul, sel_head, sel_bypass, sel_lsu, sel_any;
   logic           enq, deq;

   logic            wr_en_q, wr_en_d;
   wb_rec_t         out_q, out_d;
   logic [31:0]     cnt_q, cnt_d;

   // Source selection: mul > ALU (FIFO head, else live bypass) > LSU.
   always_comb begin
      mul_rec    = '{data: mul_data, rd: mul_rd_addr, tag: mul_instr_tag, instr: mul_instr};
      alu_rec    = '{data: alu_data, rd: alu_rd_addr, tag: alu_instr_tag, instr: alu_instr};
      lsu_rec    = '{data: lsu_data, rd: lsu_rd_addr, tag: lsu_instr_tag, instr: lsu_instr};
      fifo_empty = (count_q == '0);
      sel_mul    = mul_rd_wr_en;
      sel_head   = ~mul_rd_wr_en & ~fifo_empty;
      sel_bypass = ~mul_rd_wr_en & fifo_empty & alu_valid;
      sel_lsu    = ~mul_rd_wr_en & fifo_empty & ~alu_valid & lsu_valid;
      sel_any    = sel_mul | sel_head | sel_bypass | sel_lsu;
      // A result arriving while full is dropped, even if the head leaves this cycle.
      enq        = alu_valid & ~sel_bypass & ~full_q;
      deq        = sel_head;
      lsu_ready  = ~rst & sel_lsu;

      sel_rec = lsu_rec;
      if (sel_mul)         sel_rec = mul_rec;
      else if (sel_head)   sel_rec = fifo_q[rd_ptr_q];
      else if (sel_bypass) sel_rec = alu_rec;
   end

   // FIFO bookkeeping and output-stage next state.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      wr_en_d  = 1'b0;
      out_d    = out_q;
      cnt_d    = cnt_q;

      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
      full_d  = (count_d == CW'(ALU_DEPTH));

      if (sel_any) begin
         wr_en_d = (sel_rec.rd != 5'd0);
         out_d   = sel_rec;
         cnt_d   = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         wr_en_q  <= 1'b0;
         out_q    <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         wr_en_q  <= wr_en_d;
         out_q    <= out_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (enq) fifo_q[wr_ptr_q] <= alu_rec;
   end

   assign alu_full      = full_q;
   assign wb_wr_en      = wr_en_q;
   assign wb_rd_addr    = out_q.rd;
   assign wb_data       = out_q.data;
   assign wb_instr_tag  = out_q.tag;
   assign wb_instr      = out_q.instr;
   assign wb_retire_cnt = cnt_q;

   a_no_alu_when_full: assert property (@(posedge clk) disable iff (rst) !(alu_valid && full_q));

endmodule

// File: tb/tb_exu_wb_arb.sv
// Bench for exu_wb_arb: directed vector table, reset/wrap sequences, and random
// traffic against a queue-based reference model.
module tb_exu_wb_arb;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] mul_data, mul_instr_tag, alu_data, alu_instr_tag, lsu_data, lsu_instr_tag;
   logic [31:0]     mul_instr, alu_instr, lsu_instr;
   logic [4:0]      mul_rd_addr, alu_rd_addr, lsu_rd_addr;
   logic            mul_rd_wr_en, alu_valid, lsu_valid;
   logic            alu_full, lsu_ready, wb_wr_en;
   logic [4:0]      wb_rd_addr;
   logic [XLEN-1:0] wb_data, wb_instr_tag;
   logic [31:0]     wb_instr, wb_retire_cnt;

   always #5 clk = ~clk;

   exu_wb_arb #(.XLEN(XLEN), .ALU_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mul_data(mul_data), .mul_rd_addr(mul_rd_addr), .mul_rd_wr_en(mul_rd_wr_en),
      .mul_instr_tag(mul_instr_tag), .mul_instr(mul_instr),
      .alu_valid(alu_valid), .alu_data(alu_data), .alu_rd_addr(alu_rd_addr),
      .alu_instr_tag(alu_instr_tag), .alu_instr(alu_instr), .alu_full(alu_full),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_data(lsu_data),
      .lsu_rd_addr(lsu_rd_addr), .lsu_instr_tag(lsu_instr_tag), .lsu_instr(lsu_instr),
      .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
      .wb_instr_tag(wb_instr_tag), .wb_instr(wb_instr), .wb_retire_cnt(wb_retire_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      mul_rd_wr_en = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
   endtask

   task automatic drive_mul(input logic v, input logic [4:0] rd, input logic [31:0] d);
      mul_rd_wr_en = v; mul_rd_addr = rd; mul_data = d;
      mul_instr_tag = d ^ 32'h1000_0000; mul_instr = {27'd0, rd};
   endtask

   task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v; alu_rd_addr = rd; alu_data = d;
      alu_instr_tag = d ^ 32'h2000_0000; alu_instr = {27'd1, rd};
   endtask

   task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lsu_valid = v; lsu_rd_addr = rd; lsu_data = d;
      lsu_instr_tag = d ^ 32'h3000_0000; lsu_instr = {27'd2, rd};
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic        mv; logic [4:0] mrd; logic [31:0] md;
      logic        av; logic [4:0] ard; logic [31:0] ad;
      logic        lv; logic [4:0] lrd; logic [31:0] ld;
      logic        e_lr; logic e_wr; logic [4:0] e_rd; logic [31:0] e_d;
      logic        e_full; logic [31:0] e_cnt;
   } vec_t;

   typedef struct {
      logic [31:0] data; logic [4:0] rd; logic [31:0] tag; logic [31:0] instr;
   } rec_t;

   vec_t vt[17];

   initial begin
      // mul / alu / lsu inputs, then lsu_ready during the cycle and wb state after it
      vt[0]  = '{1,5,32'h12345678, 0,0,0,      0,0,0,       0,1,5,32'h12345678, 0, 1};
      vt[1]  = '{1,7,32'h77,       1,3,32'hA,  0,0,0,       0,1,7,32'h77,       0, 2};
      vt[2]  = '{0,0,0,            0,0,0,      0,0,0,       0,1,3,32'hA,        0, 3};
      vt[3]  = '{1,1,32'h101,      1,2,32'h202,0,0,0,       0,1,1,32'h101,      0, 4};
      vt[4]  = '{1,1,32'h102,      1,4,32'h204,0,0,0,       0,1,1,32'h102,      1, 5};
      vt[5]  = '{1,1,32'h103,      0,0,0,      0,0,0,       0,1,1,32'h103,      1, 6};
      vt[6]  = '{0,0,0,            0,0,0,      0,0,0,       0,1,2,32'h202,      0, 7};
      vt[7]  = '{0,0,0,            0,0,0,      0,0,0,       0,1,4,32'h204,      0, 8};
      vt[8]  = '{1,6,32'h61,       0,0,0,      1,9,32'h999, 0,1,6,32'h61,       0, 9};
      vt[9]  = '{1,6,32'h62,       0,0,0,      1,9,32'h999, 0,1,6,32'h62,       0,10};
      vt[10] = '{1,6,32'h63,       0,0,0,      1,9,32'h999, 0,1,6,32'h63,       0,11};
      vt[11] = '{1,6,32'h64,       0,0,0,      1,9,32'h999, 0,1,6,32'h64,       0,12};
      vt[12] = '{0,0,0,            0,0,0,      1,9,32'h999, 1,1,9,32'h999,      0,13};
      vt[13] = '{0,0,0,            0,0,0,      0,0,0,       0,0,9,32'h999,      0,13};
      vt[14] = '{0,0,0,            1,0,32'h55, 0,0,0,       0,0,0,32'h55,       0,14};
      vt[15] = '{0,0,0,            1,3,32'h33, 1,8,32'h88,  0,1,3,32'h33,       0,15};
      vt[16] = '{0,0,0,            0,0,0,      1,8,32'h88,  1,1,8,32'h88,       0,16};
   end

   initial begin
      rec_t        alu_q[$];
      rec_t        o, mrec, arec, lrec;
      logic        got, acc, lsu_pend, pre_full;
      logic        e_wr;
      rec_t        e_out;
      logic [31:0] e_cnt;

      drive_mul(0, 0, 0); drive_alu(0, 0, 0); drive_lsu(0, 0, 0);
      do_reset();

      chk("rst_wr_en", wb_wr_en, 0);
      chk("rst_rd", wb_rd_addr, 0);
      chk("rst_data", wb_data, 0);
      chk("rst_tag", wb_instr_tag, 0);
      chk("rst_instr", wb_instr, 0);
      chk("rst_cnt", wb_retire_cnt, 0);
      chk("rst_full", alu_full, 0);
      chk("rst_lsu_ready", lsu_ready, 0);

      // Directed vector table
      for (int i = 0; i < 17; i++) begin
         drive_mul(vt[i].mv, vt[i].mrd, vt[i].md);
         drive_alu(vt[i].av, vt[i].ard, vt[i].ad);
         drive_lsu(vt[i].lv, vt[i].lrd, vt[i].ld);
         #1;
         chk($sformatf("v%0d_lsu_ready", i), lsu_ready, vt[i].e_lr);
         @(posedge clk); #1;
         chk($sformatf("v%0d_wr_en", i), wb_wr_en, vt[i].e_wr);
         chk($sformatf("v%0d_rd", i), wb_rd_addr, vt[i].e_rd);
         chk($sformatf("v%0d_data", i), wb_data, vt[i].e_d);
         chk($sformatf("v%0d_full", i), alu_full, vt[i].e_full);
         chk($sformatf("v%0d_cnt", i), wb_retire_cnt, vt[i].e_cnt);
      end
      idle();

      // Fill the FIFO, then reset mid-operation: contents must vanish
      for (int i = 0; i < 2; i++) begin
         drive_mul(1, 5'd10, 32'hC0 + i);
         drive_alu(1, 5'd11, 32'hD0 + i);
         @(posedge clk); #1;
      end
      chk("fill_full", alu_full, 1);
      idle();
      lsu_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk("inrst_lsu_ready", lsu_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      lsu_valid = 1'b0;
      chk("midrst_full", alu_full, 0);
      chk("midrst_wr_en", wb_wr_en, 0);
      chk("midrst_data", wb_data, 0);
      chk("midrst_cnt", wb_retire_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("stale%0d_wr_en", i), wb_wr_en, 0);
         chk($sformatf("stale%0d_cnt", i), wb_retire_cnt, 0);
      end

      // Retire counter wrap
      drive_mul(1, 5'd2, 32'hBEEF);
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      @(posedge clk); #1;
      idle();
      chk("wrap_cnt", wb_retire_cnt, 0);
      chk("wrap_wr_en", wb_wr_en, 1);
      chk("wrap_data", wb_data, 32'hBEEF);

      // Random traffic against the reference model
      do_reset();
      alu_q.delete();
      lsu_pend = 1'b0;
      lrec = '{default: '0};
      e_wr = 1'b0; e_out = '{default: '0}; e_cnt = 32'd0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         mrec = '{$urandom, 5'($urandom_range(0, 31)), $urandom, $urandom};
         arec = '{$urandom, 5'($urandom_range(0, 31)), $urandom, $urandom};
         if (!lsu_pend && $urandom_range(0, 2) == 0) begin
            lrec = '{$urandom, 5'($urandom_range(0, 31)), $urandom, $urandom};
            lsu_pend = 1'b1;
         end
         mul_rd_wr_en = ($urandom_range(0, 3) == 0);
         mul_data = mrec.data; mul_rd_addr = mrec.rd; mul_instr_tag = mrec.tag; mul_instr = mrec.instr;
         alu_valid = (alu_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
         alu_data = arec.data; alu_rd_addr = arec.rd; alu_instr_tag = arec.tag; alu_instr = arec.instr;
         lsu_valid = lsu_pend;
         lsu_data = lrec.data; lsu_rd_addr = lrec.rd; lsu_instr_tag = lrec.tag; lsu_instr = lrec.instr;
         #1;

         got = 1'b0; acc = 1'b0; o = '{default: '0};
         pre_full = (alu_q.size() == DEPTH);
         if (mul_rd_wr_en) begin
            o = mrec; got = 1'b1;
            if (alu_valid && !pre_full) alu_q.push_back(arec);
         end else if (alu_q.size() > 0) begin
            o = alu_q.pop_front(); got = 1'b1;
            if (alu_valid && !pre_full) alu_q.push_back(arec);
         end else if (alu_valid) begin
            o = arec; got = 1'b1;
         end else if (lsu_valid) begin
            o = lrec; got = 1'b1; acc = 1'b1;
         end
         chk("rnd_lsu_ready", lsu_ready, acc);

         @(posedge clk); #1;
         if (got) begin
            e_wr = (o.rd != 5'd0); e_out = o; e_cnt = e_cnt + 32'd1;
         end else begin
            e_wr = 1'b0;
         end
         if (acc) lsu_pend = 1'b0;
         chk("rnd_wr_en", wb_wr_en, e_wr);
         chk("rnd_rd", wb_rd_addr, e_out.rd);
         chk("rnd_data", wb_data, e_out.data);
         chk("rnd_tag", wb_instr_tag, e_out.tag);
         chk("rnd_instr", wb_instr, e_out.instr);
         chk("rnd_full", alu_full, alu_q.size() == DEPTH);
         chk("rnd_cnt", wb_retire_cnt, e_cnt);
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
